// File: rtl/vdma_pkg.sv
// rtl/vdma_pkg.sv - shared constants for the VDMA read burst engine
package vdma_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   localparam int DSIZE_DEFAULT  = 64;
   localparam int BYTES_PER_BEAT = DSIZE_DEFAULT / 8;
   localparam int MAX_BURST_LEN  = 256;

   function automatic int bytes_per_beat(input int dsize);
      return dsize / 8;
   endfunction

endpackage

// File: rtl/axi_read_burst_engine_if.sv
// rtl/axi_read_burst_engine_if.sv - AXI4 read address/data channel bundle
interface axi_read_burst_engine_if #(
   parameter int ASIZE = 32,
   parameter int DSIZE = 64
);
   logic [ASIZE-1:0] araddr;
   logic [7:0]       arlen;
   logic             arvalid;
   logic             arready;
   logic [DSIZE-1:0] rdata;
   logic             rlast;
   logic             rvalid;
   logic             rready;

   modport master (
      output araddr, arlen, arvalid, rready,
      input  arready, rdata, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arvalid, rready,
      output arready, rdata, rlast, rvalid
   );
endinterface

// File: rtl/axi_read_burst_engine_frame_addr_gen.sv
// rtl/axi_read_burst_engine_frame_addr_gen.sv - frame address/remaining tracker with tail status
module frame_addr_gen
   import vdma_pkg::*;
#(
   parameter int ASIZE     = 32,
   parameter int DSIZE     = 64,
   parameter int LSIZE     = 9,
   parameter int BURST_LEN = 100,
   parameter int FSIZE     = 24
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             fsync,
   input  logic [ASIZE-1:0] base_addr,
   input  logic [FSIZE-1:0] frame_beats,
   input  logic             apply,
   input  logic             advance,
   input  logic [LSIZE-1:0] adv_len,
   output logic [ASIZE-1:0] addr,
   output logic [FSIZE-1:0] remaining,
   output logic             tail_status,
   output logic [LSIZE-1:0] tail_len
);

   localparam int BPB = bytes_per_beat(DSIZE);

   logic [ASIZE-1:0] addr_q, addr_d;
   logic [FSIZE-1:0] rem_q, rem_d;
   logic [ASIZE-1:0] pend_base_q, pend_base_d;
   logic [FSIZE-1:0] pend_beats_q, pend_beats_d;
   logic             tail_status_q, tail_status_d;
   logic [LSIZE-1:0] tail_len_q, tail_len_d;

   always_comb begin
      // The most recent fsync values win; a flush exit uses them even if fsync is coincident.
      pend_base_d  = fsync ? base_addr   : pend_base_q;
      pend_beats_d = fsync ? frame_beats : pend_beats_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      if (apply) begin
         addr_d = pend_base_d;
         rem_d  = pend_beats_d;
      end else if (advance) begin
         addr_d = addr_q + (ASIZE'(adv_len) * ASIZE'(BPB));
         rem_d  = (rem_q > FSIZE'(adv_len)) ? (rem_q - FSIZE'(adv_len)) : '0;
      end
      tail_status_d = (rem_q != '0) && (rem_q < FSIZE'(BURST_LEN));
      tail_len_d    = rem_q[LSIZE-1:0];
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         addr_q        <= '0;
         rem_q         <= '0;
         pend_base_q   <= '0;
         pend_beats_q  <= '0;
         tail_status_q <= 1'b0;
         tail_len_q    <= '0;
      end else begin
         addr_q        <= addr_d;
         rem_q         <= rem_d;
         pend_base_q   <= pend_base_d;
         pend_beats_q  <= pend_beats_d;
         tail_status_q <= tail_status_d;
         tail_len_q    <= tail_len_d;
      end
   end

   assign addr        = addr_q;
   assign remaining   = rem_q;
   assign tail_status = tail_status_q;
   assign tail_len    = tail_len_q;

endmodule

// File: rtl/axi_read_burst_engine.sv
// rtl/axi_read_burst_engine.sv - single-outstanding AXI4 read burst engine feeding the line FIFO
module axi_read_burst_engine
   import vdma_pkg::*;
#(
   parameter int ASIZE     = 32,
   parameter int DSIZE     = 64,
   parameter int LSIZE     = 9,
   parameter int BURST_LEN = 100,
   parameter int FSIZE     = 24
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    fsync,
   input  logic [ASIZE-1:0]        base_addr,
   input  logic [FSIZE-1:0]        frame_beats,
   input  logic                    burst_req,
   input  logic                    tail_req,
   input  logic [LSIZE-1:0]        req_len,
   output logic                    resp,
   output logic                    done,
   output logic                    tail_status,
   output logic [LSIZE-1:0]        tail_len,
   output logic                    err,
   axi_read_burst_engine_if.master axi,
   output logic                    fifo_wr_en,
   output logic [DSIZE-1:0]        fifo_wr_data
);

   logic [2:0]       state_q, state_d;
   logic [LSIZE-1:0] len_q, len_d;
   logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;
   logic             err_q, err_d;
   logic             fsync_seen_q, fsync_seen_d;

   logic [ASIZE-1:0] addr;
   logic [FSIZE-1:0] remaining;
   logic             apply;
   logic             advance;
   logic             last_beat;

   frame_addr_gen #(
      .ASIZE     (ASIZE),
      .DSIZE     (DSIZE),
      .LSIZE     (LSIZE),
      .BURST_LEN (BURST_LEN),
      .FSIZE     (FSIZE)
   ) u_frame_addr_gen (
      .clock       (clock),
      .rst         (rst),
      .fsync       (fsync),
      .base_addr   (base_addr),
      .frame_beats (frame_beats),
      .apply       (apply),
      .advance     (advance),
      .adv_len     (len_q),
      .addr        (addr),
      .remaining   (remaining),
      .tail_status (tail_status),
      .tail_len    (tail_len)
   );

   assign last_beat = (beat_cnt_q == len_q - 1'b1);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      err_d        = err_q;
      fsync_seen_d = fsync_seen_q;
      resp         = 1'b0;
      done         = 1'b0;
      apply        = 1'b0;
      advance      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fsync) begin
               apply = 1'b1;
            end else if ((burst_req || tail_req) && req_len != '0 && remaining != '0) begin
               state_d      = ST_ADDR;
               len_d        = req_len;
               beat_cnt_d   = '0;
               fsync_seen_d = 1'b0;
            end
         end
         ST_ADDR: begin
            // arvalid must not drop before the handshake, so an fsync here is only remembered.
            if (fsync) fsync_seen_d = 1'b1;
            if (axi.arready) begin
               advance    = 1'b1;
               beat_cnt_d = '0;
               if (fsync || fsync_seen_q) begin
                  state_d = ST_FLUSH;
               end else begin
                  resp    = 1'b1;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (axi.rvalid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (axi.rlast != last_beat) err_d = 1'b1;
            end
            if (fsync) state_d = ST_FLUSH;
            else if (axi.rvalid && last_beat) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (fsync) begin
               state_d = ST_FLUSH;
            end else begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (axi.rvalid && beat_cnt_q != len_q) beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_d == len_q) begin
               apply   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (fsync) err_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         err_q        <= 1'b0;
         fsync_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         err_q        <= err_d;
         fsync_seen_q <= fsync_seen_d;
      end
   end

   assign err          = err_q;
   assign axi.arvalid  = (state_q == ST_ADDR);
   assign axi.araddr   = axi.arvalid ? addr : '0;
   assign axi.arlen    = axi.arvalid ? 8'(len_q - 1'b1) : 8'd0;
   assign axi.rready   = (state_q == ST_DATA) || (state_q == ST_FLUSH);
   assign fifo_wr_en   = (state_q == ST_DATA) && axi.rvalid;
   assign fifo_wr_data = fifo_wr_en ? axi.rdata : '0;

endmodule
